ccc_pll_sequencer: RTL

Controls one FCCC/PLL instance from the free-running fabric RC-oscillator clock.
- Sequences PLL power-up and reset release.
- Qualifies LOCK and publishes a filtered PLL_READY.
- Recovers from lock loss with bounded retries, ending in FAULT.
- Performs single-register dynamic reconfiguration writes over the CCC's 8-bit APB port, with an optional relock afterwards.

---
 rtl/ccc_seq_pkg.sv | 18 +
 rtl/ccc_lock_filter.sv | 57 +++++
 rtl/ccc_pll_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ccc_seq_pkg.sv
// Shared state encoding and APB widths for the FCCC/PLL sequencer.
package ccc_seq_pkg;

    localparam int CCC_APB_AW = 6;
    localparam int CCC_APB_DW = 8;
    localparam int RETRY_W    = 4;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RST_HOLD,
        ST_WAIT_LOCK,
        ST_LOCKED,
        ST_APB_SETUP,
        ST_APB_ACCESS,
        ST_FAULT
    } seq_state_t;

endpackage

// File: rtl/ccc_lock_filter.sv
// LOCK synchronizer with consecutive-high and consecutive-low qualifiers.
module ccc_lock_filter
    import ccc_seq_pkg::*;
#(
    parameter int LOCK_FILTER = 256,
    parameter int LOSS_FILTER = 4,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic lock,
    input  logic restart,
    output logic lock_ok,
    output logic lock_loss
);

    localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(LOSS_FILTER - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic             lock_m;
    logic             lock_s;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] lo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= lock;
            lock_s <= lock_m;
        end
    end

    // Counters saturate one short of the target; the qualifying cycle
    // itself completes the run so the FSM can act on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else if (restart) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else if (lock_s) begin
            lo_cnt <= '0;
            if (hi_cnt != HI_LAST) hi_cnt <= hi_cnt + ONE;
        end else begin
            hi_cnt <= '0;
            if (lo_cnt != LO_LAST) lo_cnt <= lo_cnt + ONE;
        end
    end

    assign lock_ok   = lock_s && (hi_cnt == HI_LAST);
    assign lock_loss = !lock_s && (lo_cnt == LO_LAST);

endmodule

// File: rtl/ccc_pll_sequencer.sv
// FCCC/PLL power-up, lock qualification, retry and APB reconfiguration.
module ccc_pll_sequencer
    import ccc_seq_pkg::*;
#(
    parameter int RST_CYCLES   = 64,
    parameter int LOCK_FILTER  = 256,
    parameter int LOSS_FILTER  = 4,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int MAX_RETRY    = 3,
    parameter int CNT_W        = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic                  LOCK,
    input  logic                  BUSY,
    output logic                  PLL_ARST_N,
    output logic                  PLL_POWERDOWN_N,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [CCC_APB_AW-1:0] PADDR,
    output logic [CCC_APB_DW-1:0] PWDATA,
    input  logic                  CFG_REQ,
    input  logic [CCC_APB_AW-1:0] CFG_ADDR,
    input  logic [CCC_APB_DW-1:0] CFG_DATA,
    input  logic                  CFG_RELOCK,
    output logic                  CFG_ACK,
    input  logic                  CLR_STATUS,
    output logic                  PLL_READY,
    output logic                  LOCK_LOST,
    output logic                  FAULT,
    output logic [RETRY_W-1:0]    RETRY_CNT
);

    localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   ONE      = CNT_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_MX = RETRY_W'(MAX_RETRY);

    seq_state_t       state;
    seq_state_t       ret_state;
    logic [CNT_W-1:0] timer;
    logic             relock_q;
    logic             restart;
    logic             lock_ok;
    logic             lock_loss;
    logic             in_apb;
    logic             accept;

    assign restart = !(state == ST_WAIT_LOCK || state == ST_LOCKED);
    assign in_apb  = (state == ST_APB_SETUP) || (state == ST_APB_ACCESS);

    // The ACK cycle is excluded so a still-high request is not taken twice.
    assign accept = CFG_REQ && !CFG_ACK &&
                    ((state == ST_OFF) ||
                     (ENABLE && ((state == ST_FAULT) ||
                                 (state == ST_LOCKED && !lock_loss))));

    ccc_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER),
        .LOSS_FILTER (LOSS_FILTER),
        .CNT_W       (CNT_W)
    ) u_filter (
        .clk       (CLK),
        .rst       (RESET),
        .lock      (LOCK),
        .restart   (restart),
        .lock_ok   (lock_ok),
        .lock_loss (lock_loss)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state           <= ST_OFF;
            ret_state       <= ST_OFF;
            timer           <= '0;
            relock_q        <= 1'b0;
            PLL_ARST_N      <= 1'b0;
            PLL_POWERDOWN_N <= 1'b0;
            PSEL            <= 1'b0;
            PENABLE         <= 1'b0;
            PWRITE          <= 1'b0;
            PADDR           <= '0;
            PWDATA          <= '0;
            CFG_ACK         <= 1'b0;
            PLL_READY       <= 1'b0;
            LOCK_LOST       <= 1'b0;
            FAULT           <= 1'b0;
            RETRY_CNT       <= '0;
        end else begin
            CFG_ACK <= 1'b0;
            if (CLR_STATUS) LOCK_LOST <= 1'b0;
            if (accept) begin
                ret_state <= state;
                relock_q  <= CFG_RELOCK;
                PADDR     <= CFG_ADDR;
                PWDATA    <= CFG_DATA;
                PSEL      <= 1'b1;
                PWRITE    <= 1'b1;
                PENABLE   <= 1'b0;
                state     <= ST_APB_SETUP;
            end else if (!ENABLE && !in_apb) begin
                state           <= ST_OFF;
                timer           <= '0;
                PLL_ARST_N      <= 1'b0;
                PLL_POWERDOWN_N <= 1'b0;
                PLL_READY       <= 1'b0;
                FAULT           <= 1'b0;
                RETRY_CNT       <= '0;
            end else begin
                unique case (state)
                    ST_OFF: begin
                        state           <= ST_RST_HOLD;
                        timer           <= '0;
                        PLL_ARST_N      <= 1'b0;
                        PLL_POWERDOWN_N <= 1'b1;
                    end
                    ST_RST_HOLD: begin
                        if (timer == RST_LAST) begin
                            state      <= ST_WAIT_LOCK;
                            timer      <= '0;
                            PLL_ARST_N <= 1'b1;
                        end else begin
                            timer <= timer + ONE;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (lock_ok) begin
                            state     <= ST_LOCKED;
                            PLL_READY <= 1'b1;
                            RETRY_CNT <= '0;
                        end else if (timer == TO_LAST) begin
                            timer      <= '0;
                            PLL_ARST_N <= 1'b0;
                            if (RETRY_CNT == RETRY_MX) begin
                                state <= ST_FAULT;
                                FAULT <= 1'b1;
                            end else begin
                                state     <= ST_RST_HOLD;
                                RETRY_CNT <= RETRY_CNT + 1'b1;
                            end
                        end else begin
                            timer <= timer + ONE;
                        end
                    end
                    ST_LOCKED: begin
                        if (lock_loss) begin
                            state      <= ST_RST_HOLD;
                            timer      <= '0;
                            PLL_ARST_N <= 1'b0;
                            PLL_READY  <= 1'b0;
                            LOCK_LOST  <= 1'b1;
                        end
                    end
                    ST_APB_SETUP: begin
                        PENABLE <= 1'b1;
                        state   <= ST_APB_ACCESS;
                    end
                    ST_APB_ACCESS: begin
                        if (!BUSY) begin
                            PSEL    <= 1'b0;
                            PENABLE <= 1'b0;
                            PWRITE  <= 1'b0;
                            CFG_ACK <= 1'b1;
                            timer   <= '0;
                            if (!ENABLE) begin
                                state           <= ST_OFF;
                                PLL_ARST_N      <= 1'b0;
                                PLL_POWERDOWN_N <= 1'b0;
                                PLL_READY       <= 1'b0;
                                FAULT           <= 1'b0;
                                RETRY_CNT       <= '0;
                            end else if (relock_q) begin
                                state           <= ST_RST_HOLD;
                                PLL_ARST_N      <= 1'b0;
                                PLL_POWERDOWN_N <= 1'b1;
                                PLL_READY       <= 1'b0;
                                FAULT           <= 1'b0;
                                RETRY_CNT       <= '0;
                            end else begin
                                state <= ret_state;
                            end
                        end
                    end
                    ST_FAULT: begin
                        state <= ST_FAULT;
                    end
                    default: state <= ST_OFF;
                endcase
            end
        end
    end

endmodule
